// File: rtl/alu_div_seq_if.sv
// Bundle between alu_div_seq, the issue stage and the ALU.
// master: issue stage plus ALU side (drives requests, host ops and ALU results).
// slave:  the divide sequencer.
interface alu_div_seq_if;
  // Divide request and result
  logic        start;
  logic        signed_op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div0;
  logic [31:0] quotient;
  logic [31:0] remainder;
  // Host pass-through request
  logic [3:0]  host_inst;
  logic [31:0] host_a;
  logic [31:0] host_b;
  logic        host_ci;
  logic        host_gnt;
  // ALU port
  logic [3:0]  alu_inst;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_ci;
  logic        alu_first;
  logic [31:0] alu_z;
  logic [3:0]  alu_flags;

  modport master (
    output start, signed_op, dividend, divisor,
    output host_inst, host_a, host_b, host_ci,
    output alu_z, alu_flags,
    input  busy, done, div0, quotient, remainder, host_gnt,
    input  alu_inst, alu_a, alu_b, alu_ci, alu_first
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    input  host_inst, host_a, host_b, host_ci,
    input  alu_z, alu_flags,
    output busy, done, div0, quotient, remainder, host_gnt,
    output alu_inst, alu_a, alu_b, alu_ci, alu_first
  );
endinterface

// File: rtl/alu_div_seq.sv
// Multi-cycle restoring divide sequencer in front of the 32-bit ALU.
// Each of the 32 steps borrows the ALU subtract; when idle the ALU is handed to the host.
// Optional signed support is compiled in with `define ALU_DIV_SIGNED_EN.
module alu_div_seq #(
  parameter logic [3:0] SubInst = 4'h3
) (
  input logic          clk_i,
  input logic          rst_ni,
  alu_div_seq_if.slave bus
);

  localparam int unsigned Steps   = 32;
  localparam logic [4:0]  LastCnt = 5'(Steps - 1);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StStep   = 2'd1;
`ifdef ALU_DIV_SIGNED_EN
  localparam logic [1:0] StFixIn  = 2'd2;
  localparam logic [1:0] StFixOut = 2'd3;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] q_q, q_d;
  logic [31:0] r_q, r_d;
  logic [31:0] dvs_q, dvs_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;

`ifdef ALU_DIV_SIGNED_EN
  logic fix_q, fix_d;
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;
`else
  logic unused_signed;
  assign unused_signed = bus.signed_op;
`endif

  logic [31:0] shift_r;
  logic        ok;
  logic        unused_flags;

  // Partial remainder shifted left with the next dividend bit. If r[31] was set the
  // true value is 33 bits and always >= divisor; ALU_Z is still correct mod 2^32.
  assign shift_r      = {r_q[30:0], q_q[31]};
  assign ok           = bus.alu_flags[1] | r_q[31];
  assign unused_flags = ^{bus.alu_flags[3:2], bus.alu_flags[0]};

  // Next-state logic for the sequencer and result registers
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
`ifdef ALU_DIV_SIGNED_EN
    fix_d      = fix_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
`endif
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.divisor == '0) begin
            // Divide by zero resolves immediately, no steps
            quot_d = '1;
            rem_d  = bus.dividend;
            done_d = 1'b1;
            div0_d = 1'b1;
          end else begin
            q_d     = bus.dividend;
            r_d     = '0;
            dvs_d   = bus.divisor;
            cnt_d   = '0;
            state_d = StStep;
`ifdef ALU_DIV_SIGNED_EN
            fix_d = bus.signed_op;
            if (bus.signed_op) state_d = StFixIn;
`endif
          end
        end
      end
      StStep: begin
        r_d   = ok ? bus.alu_z : shift_r;
        q_d   = {q_q[30:0], ok};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          quot_d  = q_d;
          rem_d   = r_d;
          done_d  = 1'b1;
`ifdef ALU_DIV_SIGNED_EN
          if (fix_q) begin
            state_d = StFixOut;
            quot_d  = quot_q;
            rem_d   = rem_q;
            done_d  = 1'b0;
          end
`endif
        end
      end
`ifdef ALU_DIV_SIGNED_EN
      StFixIn: begin
        // Divide magnitudes; 0x80000000 stays 0x80000000, which is its magnitude unsigned
        q_d        = q_q[31] ? -q_q : q_q;
        dvs_d      = dvs_q[31] ? -dvs_q : dvs_q;
        neg_quot_d = q_q[31] ^ dvs_q[31];
        neg_rem_d  = q_q[31];
        state_d    = StStep;
      end
      StFixOut: begin
        quot_d  = neg_quot_q ? -q_q : q_q;
        rem_d   = neg_rem_q ? -r_q : r_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      q_q     <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

`ifdef ALU_DIV_SIGNED_EN
  // Sign bookkeeping for the signed build
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fix_q      <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      fix_q      <= fix_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`endif

  // ALU mux: host pass-through when idle, divide step otherwise; START beats the host
  always_comb begin
    if (state_q == StIdle) begin
      bus.alu_inst = bus.host_inst;
      bus.alu_a    = bus.host_a;
      bus.alu_b    = bus.host_b;
      bus.alu_ci   = bus.host_ci;
      bus.host_gnt = ~bus.start;
    end else begin
      bus.alu_inst = SubInst;
      bus.alu_a    = shift_r;
      bus.alu_b    = dvs_q;
      bus.alu_ci   = 1'b1;
      bus.host_gnt = 1'b0;
    end
    bus.alu_first = 1'b1;
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = done_q;
  assign bus.div0      = div0_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;

endmodule

// File: tb/tb_alu_div_seq.sv
// Scoreboard bench for alu_div_seq: driver pushes model results, monitor pops on DONE.
module tb_alu_div_seq;

`ifdef ALU_DIV_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_div_seq_if bus ();

  alu_div_seq u_dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  // Behavioural ALU: INST 3 is A-B with carry meaning no borrow, anything else adds
  logic [32:0] alu_sum;
  always_comb begin
    if (bus.alu_inst == 4'h3) alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
    else alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {32'd0, bus.alu_ci};
    bus.alu_z     = alu_sum[31:0];
    bus.alu_flags = {2'b00, alu_sum[32], alu_sum[31:0] == 32'd0};
  end

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        div0;
    int unsigned done_edge;
    int unsigned busy;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned edge_cnt   = 0;
  int unsigned busy_run   = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Reference: plain arithmetic on the operands
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t e;
    e.div0      = (b == 32'd0);
    e.busy      = 32;
    e.done_edge = 0;
    if (b == 32'd0) begin
      e.q    = '1;
      e.r    = a;
      e.busy = 0;
    end else if (s && SignedEn) begin
      e.busy = 34;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = 32'd0;
      end else begin
        e.q = 32'($signed(a) / $signed(b));
        e.r = 32'($signed(a) % $signed(b));
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance (or in DONE)
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                       input bit hold, input bit push);
    exp_t        e;
    int unsigned guard = 0;
    while (bus.busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) fail("idle_timeout");
    bus.start     = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    bus.signed_op = s;
    @(posedge clk);
    #1;
    e = model(a, b, s);
    e.done_edge = edge_cnt + e.busy;
    if (push) exp_q.push_back(e);
    bus.start = 1'b0;
    if (hold && b != 32'd0) begin
      bus.start = 1'($urandom);
      guard = 0;
      while (!bus.done && guard < 100) begin
        @(negedge clk);
        if (!bus.done) bus.start = 1'($urandom);
        guard++;
      end
      bus.start = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int unsigned guard = 0;
    while (!bus.done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.done) fail("done_timeout");
  endtask

  // Host traffic is always pending
  initial begin
    bus.host_inst = 4'h0;
    bus.host_a    = 32'd0;
    bus.host_b    = 32'd0;
    bus.host_ci   = 1'b0;
    forever begin
      @(negedge clk);
      bus.host_inst = 4'($urandom);
      bus.host_a    = $urandom;
      bus.host_b    = $urandom;
      bus.host_ci   = 1'($urandom);
    end
  end

  // Monitor: grant rules every cycle, scoreboard pop on DONE
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        busy_run = 0;
      end else begin
        if (bus.busy) begin
          busy_run++;
          check("gnt_busy", 32'(bus.host_gnt), 32'd0);
        end else if (bus.start) begin
          check("gnt_start", 32'(bus.host_gnt), 32'd0);
        end else begin
          check("gnt_idle", 32'(bus.host_gnt), 32'd1);
          check("pass_inst", 32'(bus.alu_inst), 32'(bus.host_inst));
          check("pass_a", bus.alu_a, bus.host_a);
          check("pass_b", bus.alu_b, bus.host_b);
          check("pass_ci", 32'(bus.alu_ci), 32'(bus.host_ci));
        end
        if (bus.done) begin
          if (exp_q.size() == 0) begin
            fail("unexpected_done");
          end else begin
            e = exp_q.pop_front();
            check("quotient", bus.quotient, e.q);
            check("remainder", bus.remainder, e.r);
            check("div0", 32'(bus.div0), 32'(e.div0));
            check("done_edge", edge_cnt, e.done_edge);
            check("busy_cycles", busy_run, e.busy);
          end
          busy_run = 0;
        end
      end
    end
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd0;
    bus.divisor   = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_div0", 32'(bus.div0), 32'd0);
    check("rst_quot", bus.quotient, 32'd0);
    check("rst_rem", bus.remainder, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 1'b0, 1'b1);
    wait_done();
    issue(32'h1234, 32'd0, 1'b0, 1'b0, 1'b1);
    wait_done();
    // START held and toggled while busy, then back-to-back START in the DONE cycle
    issue(32'd1000, 32'd3, 1'b0, 1'b1, 1'b1);
    wait_done();
    issue(32'd77, 32'd77, 1'b0, 1'b0, 1'b1);
    wait_done();
    repeat (2) @(negedge clk);

    // Abort mid-divide: no result may appear for this one
    issue(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_quot", bus.quotient, 32'd0);
    check("abort_rem", bus.remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(32'd9, 32'd3, 1'b0, 1'b0, 1'b1);
    wait_done();

    if (SignedEn) begin
      issue(-32'sd7, 32'd2, 1'b1, 1'b0, 1'b1);
      wait_done();
      issue(32'd7, -32'sd2, 1'b1, 1'b0, 1'b1);
      wait_done();
      issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1);
      wait_done();
      issue(-32'sd5, 32'd0, 1'b1, 1'b0, 1'b1);
      wait_done();
    end

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: b = $urandom;
      endcase
      issue(a, b, 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b1);
      wait_done();
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) fail("results_pending");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
